// File: rtl/mesh_sink_monitor.sv
// mesh_sink_monitor: round-robin sink for up to eight packet channels.
// Accepts one packet per grant and optionally stalls for BL cycles after each
// accept. Counts accepted and misrouted packets, latches the first misrouted
// packet, and keeps the most recently accepted packet and its channel.
module mesh_sink_monitor #(
  parameter int NODE     = 0,
  parameter int WIDTH    = 57,
  parameter int NCH      = 4,
  parameter int ADDR_LSB = 0,
  parameter int ADDR_W   = 4,
  parameter int CNT_W    = 16,
  parameter int BL       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  input  logic                 clr,
  output logic [CNT_W-1:0]     pkt_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 err_flag,
  output logic [WIDTH-1:0]     first_err,
  output logic [WIDTH-1:0]     last_data,
  output logic [2:0]           last_ch,
  output logic                 acc_pulse
);

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} stateE;

  localparam logic [ADDR_W-1:0] NODE_ADDR = ADDR_W'(NODE);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  stateE            state;
  logic [2:0]       ptr;
  logic [7:0]       holdCnt;
  logic [CNT_W-1:0] pktCnt;
  logic [CNT_W-1:0] errCnt;
  logic             errFlag;
  logic [WIDTH-1:0] firstErr;
  logic [WIDTH-1:0] lastData;
  logic [2:0]       lastCh;
  logic             accPulse;

  // Padding to eight lanes lets a 3-bit index address any channel exactly.
  logic [7:0]       validPad;
  logic [7:0]       readyPad;
  logic             found;
  logic [2:0]       grantIdx;
  logic [2:0]       cand;
  logic [WIDTH-1:0] xferData;
  logic             misroute;

  assign validPad = 8'(in_valid);

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    found    = 1'b0;
    grantIdx = ptr;
    cand     = 3'd0;
    readyPad = 8'd0;
    if ((state == IDLE) && !rst) begin
      for (int k = 1; k <= NCH; k++) begin
        cand = 3'((int'(ptr) + k) % NCH);
        if (!found && validPad[cand]) begin
          found    = 1'b1;
          grantIdx = cand;
        end else begin
        end
      end
    end else begin
    end
    if (found) begin
      readyPad[grantIdx] = 1'b1;
    end else begin
    end
  end

  assign in_ready = readyPad[NCH-1:0];

  // Select the packet on the granted channel and classify its destination.
  always_comb begin
    xferData = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grantIdx == 3'(i)) begin
        xferData = in_data[i*WIDTH +: WIDTH];
      end else begin
      end
    end
    misroute = found && (xferData[ADDR_LSB +: ADDR_W] != NODE_ADDR);
  end

  // Arbitration state, stall timer and capture of the accepted packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 3'(NCH - 1);
      holdCnt  <= 8'd0;
      lastData <= '0;
      lastCh   <= 3'd0;
      accPulse <= 1'b0;
    end else begin
      accPulse <= found;
      if (found) begin
        lastData <= xferData;
        lastCh   <= grantIdx;
        ptr      <= grantIdx;
      end else begin
      end
      case (state)
        IDLE: begin
          if (found && (BL > 0)) begin
            state   <= HOLD;
            holdCnt <= 8'(BL);
          end else begin
            state   <= IDLE;
            holdCnt <= 8'd0;
          end
        end
        HOLD: begin
          if (holdCnt <= 8'd1) begin
            state   <= IDLE;
            holdCnt <= 8'd0;
          end else begin
            holdCnt <= holdCnt - 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          holdCnt <= 8'd0;
        end
      endcase
    end
  end

  // Saturating counters and sticky error capture; clear beats a transfer.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pktCnt   <= '0;
      errCnt   <= '0;
      errFlag  <= 1'b0;
      firstErr <= '0;
    end else if (found) begin
      if (pktCnt != CNT_MAX) begin
        pktCnt <= pktCnt + 1'b1;
      end else begin
      end
      if (misroute) begin
        errFlag <= 1'b1;
        if (errCnt != CNT_MAX) begin
          errCnt <= errCnt + 1'b1;
        end else begin
        end
        if (!errFlag) begin
          firstErr <= xferData;
        end else begin
        end
      end else begin
      end
    end else begin
    end
  end

  assign pkt_cnt   = pktCnt;
  assign err_cnt   = errCnt;
  assign err_flag  = errFlag;
  assign first_err = firstErr;
  assign last_data = lastData;
  assign last_ch   = lastCh;
  assign acc_pulse = accPulse;

endmodule

// File: tb/tb_mesh_sink_monitor.sv
// Directed bench for mesh_sink_monitor: instance A (NODE=5, BL=0, CNT_W=4)
// and instance B (NODE=5, BL=3, CNT_W=16) share clock and reset.
module tb_mesh_sink_monitor;

  localparam int W   = 57;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NCH-1:0]   valA = '0, readyA;
  logic [NCH*W-1:0] dataA = '0;
  logic             clrA = 1'b0;
  logic [3:0]       pktA, errA;
  logic             flagA, accA;
  logic [W-1:0]     firstA, lastA;
  logic [2:0]       chA;

  logic [NCH-1:0]   valB = '0, readyB;
  logic [NCH*W-1:0] dataB = '0;
  logic             clrB = 1'b0;
  logic [15:0]      pktB, errB;
  logic             flagB, accB;
  logic [W-1:0]     firstB, lastB;
  logic [2:0]       chB;

  int nVec = 0;
  int nMiss = 0;

  always #5 clk = ~clk;

  mesh_sink_monitor #(.NODE(5), .WIDTH(W), .NCH(NCH), .ADDR_LSB(0), .ADDR_W(4),
                      .CNT_W(4), .BL(0)) dutA (
    .clk(clk), .rst(rst), .in_valid(valA), .in_data(dataA), .in_ready(readyA),
    .clr(clrA), .pkt_cnt(pktA), .err_cnt(errA), .err_flag(flagA),
    .first_err(firstA), .last_data(lastA), .last_ch(chA), .acc_pulse(accA));

  mesh_sink_monitor #(.NODE(5), .WIDTH(W), .NCH(NCH), .ADDR_LSB(0), .ADDR_W(4),
                      .CNT_W(16), .BL(3)) dutB (
    .clk(clk), .rst(rst), .in_valid(valB), .in_data(dataB), .in_ready(readyB),
    .clr(clrB), .pkt_cnt(pktB), .err_cnt(errB), .err_flag(flagB),
    .first_err(firstB), .last_data(lastB), .last_ch(chB), .acc_pulse(accB));

  function automatic logic [W-1:0] pk(input logic [52:0] tag, input logic [3:0] dest);
    return {tag, dest};
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nMiss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, then let combinational logic settle.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset: in_ready held low even with every channel valid.
    valA = 4'hF;
    step();
    step();
    checkVal("rst_readyA", 64'(readyA), 64'h0);
    rst = 1'b0;
    valA = 4'h0;
    #1;
    checkVal("rst_pktA", 64'(pktA), 64'h0);
    checkVal("rst_errA", 64'(errA), 64'h0);
    checkVal("rst_lastA", 64'(lastA), 64'h0);
    checkVal("rst_accA", 64'(accA), 64'h0);

    // All four channels valid with dest 5: strict round robin from channel 0.
    for (int i = 0; i < NCH; i++) dataA[i*W +: W] = pk(53'(16'hA0 + i), 4'd5);
    valA = 4'hF;
    #1;
    for (int c = 0; c < 8; c++) begin
      checkVal($sformatf("rr_grant%0d", c), 64'(readyA), 64'(4'b0001 << (c % 4)));
      step();
    end
    valA = 4'h0;
    #1;
    checkVal("rr_pkt", 64'(pktA), 64'd8);
    checkVal("rr_err", 64'(errA), 64'd0);
    checkVal("rr_lastch", 64'(chA), 64'd3);
    checkVal("rr_lastdata", 64'(lastA), 64'(pk(53'h0A3, 4'd5)));
    checkVal("rr_acc", 64'(accA), 64'd1);
    step();
    checkVal("rr_acc_drop", 64'(accA), 64'd0);

    // Clear, then dest 5, 7, 9 on channel 1.
    clrA = 1'b1;
    step();
    clrA = 1'b0;
    #1;
    checkVal("clr_pkt", 64'(pktA), 64'd0);
    dataA[1*W +: W] = pk(53'h111, 4'd5);
    valA = 4'b0010;
    #1;
    checkVal("mis_grant0", 64'(readyA), 64'h2);
    step();
    dataA[1*W +: W] = pk(53'h222, 4'd7);
    #1;
    checkVal("mis_grant1", 64'(readyA), 64'h2);
    step();
    dataA[1*W +: W] = pk(53'h333, 4'd9);
    #1;
    checkVal("mis_grant2", 64'(readyA), 64'h2);
    step();
    valA = 4'h0;
    #1;
    checkVal("mis_errcnt", 64'(errA), 64'd2);
    checkVal("mis_flag", 64'(flagA), 64'd1);
    checkVal("mis_first", 64'(firstA), 64'(pk(53'h222, 4'd7)));
    checkVal("mis_pkt", 64'(pktA), 64'd3);
    checkVal("mis_last", 64'(lastA), 64'(pk(53'h333, 4'd9)));

    // Clear coincident with a misrouted accept on channel 2.
    dataA[2*W +: W] = pk(53'h777, 4'd3);
    valA = 4'b0100;
    clrA = 1'b1;
    #1;
    checkVal("clrx_grant", 64'(readyA), 64'h4);
    step();
    valA = 4'h0;
    clrA = 1'b0;
    #1;
    checkVal("clrx_err", 64'(errA), 64'd0);
    checkVal("clrx_flag", 64'(flagA), 64'd0);
    checkVal("clrx_pkt", 64'(pktA), 64'd0);
    checkVal("clrx_first", 64'(firstA), 64'd0);
    checkVal("clrx_last", 64'(lastA), 64'(pk(53'h777, 4'd3)));
    checkVal("clrx_ch", 64'(chA), 64'd2);

    // Twenty accepts saturate the 4-bit counter at 15.
    for (int i = 0; i < NCH; i++) dataA[i*W +: W] = pk(53'(16'hB0 + i), 4'd5);
    valA = 4'hF;
    repeat (20) step();
    valA = 4'h0;
    #1;
    checkVal("sat_pkt", 64'(pktA), 64'd15);
    checkVal("sat_err", 64'(errA), 64'd0);

    // BL=3: channel 2 continuously valid, granted one cycle in four.
    dataB[2*W +: W] = pk(53'h2B2, 4'd5);
    valB = 4'b0100;
    #1;
    for (int c = 0; c < 12; c++) begin
      checkVal($sformatf("hold_ready%0d", c), 64'(readyB),
               (c % 4 == 0) ? 64'h4 : 64'h0);
      step();
    end
    checkVal("hold_pkt", 64'(pktB), 64'd3);
    checkVal("hold_grant12", 64'(readyB), 64'h4);
    step();
    step();
    // Second HOLD cycle: assert reset with every channel valid.
    for (int i = 0; i < NCH; i++) dataB[i*W +: W] = pk(53'(16'hC0 + i), 4'd5);
    valB = 4'hF;
    rst = 1'b1;
    #1;
    checkVal("hrst_ready_in_rst", 64'(readyB), 64'h0);
    step();
    rst = 1'b0;
    #1;
    checkVal("hrst_ready", 64'(readyB), 64'h1);
    checkVal("hrst_pkt", 64'(pktB), 64'd0);
    checkVal("hrst_acc", 64'(accB), 64'd0);
    checkVal("hrst_last", 64'(lastB), 64'd0);
    checkVal("hrst_ch", 64'(chB), 64'd0);
    checkVal("hrst_flag", 64'(flagB), 64'd0);
    step();
    valB = 4'h0;
    #1;
    checkVal("hrst_accept0", 64'(lastB), 64'(pk(53'h0C0, 4'd5)));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule

// File: doc/mesh_sink_monitor.md
MESH_SINK_MONITOR -- requirements
Module: mesh_sink_monitor

Interface
REQ-001 SHALL have parameter NODE, default 0, this node's mesh address.
REQ-002 SHALL have parameter WIDTH, default 57, packet width in bits.
REQ-003 SHALL have parameter NCH, default 4, input channel count (1..8).
REQ-004 SHALL have parameter ADDR_LSB, default 0, and ADDR_W, default 4; the destination field is pkt[ADDR_LSB +: ADDR_W].
REQ-005 SHALL have parameter CNT_W, default 16, counter width.
REQ-006 SHALL have parameter BL, default 0, stall cycles after each accepted packet (0..255).
REQ-007 Ports: clk  in  1  sole clock, all state on rising edge.
REQ-008 Ports: rst  in  1  synchronous, active-high reset.
REQ-009 Ports: in_valid  in  NCH  per-channel packet valid.
REQ-010 Ports: in_data  in  NCH*WIDTH  channel i packet at [i*WIDTH +: WIDTH].
REQ-011 Ports: in_ready  out  NCH  per-channel accept.
REQ-012 Ports: clr  in  1  synchronous clear of counters and error state.
REQ-013 Ports: pkt_cnt  out  CNT_W  total packets accepted.
REQ-014 Ports: err_cnt  out  CNT_W  misrouted packets accepted.
REQ-015 Ports: err_flag  out  1  sticky, set on first misroute.
REQ-016 Ports: first_err  out  WIDTH  first misrouted packet.
REQ-017 Ports: last_data  out  WIDTH  most recently accepted packet.
REQ-018 Ports: last_ch  out  3  channel index of last_data.
REQ-019 Ports: acc_pulse  out  1  one-cycle strobe, high the cycle after an accept.

Function
REQ-020 Transfer on channel i SHALL occur on the rising edge where in_valid[i] & in_ready[i]; sender holds valid and data until transfer.
REQ-021 At most one in_ready bit SHALL be high in any cycle; in_ready SHALL be combinational from in_valid, state and pointer.
REQ-022 FSM states: IDLE (grant allowed), HOLD (all in_ready low).
REQ-023 IDLE: if any in_valid, grant the first valid channel searching ptr+1, ptr+2, ... modulo NCH; else all in_ready low.
REQ-024 On transfer ptr SHALL become the granted index; next IDLE cycle gives that channel lowest priority.
REQ-025 On transfer with BL>0 SHALL enter HOLD for exactly BL cycles, then IDLE; with BL=0 SHALL stay IDLE (back-to-back accepts every cycle).
REQ-026 On transfer: last_data, last_ch SHALL update next cycle; acc_pulse high for exactly that one cycle.
REQ-027 On transfer pkt_cnt SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-028 Packet is misrouted when dest field != NODE[ADDR_W-1:0]; then err_cnt increments (saturating) and err_flag sets.
REQ-029 first_err SHALL capture only when err_flag is low at the transfer; later misroutes do not overwrite it.
REQ-030 clr SHALL zero pkt_cnt, err_cnt, err_flag, first_err next cycle; FSM, ptr, last_data, last_ch unaffected.
REQ-031 clr coincident with transfer: clear wins for counters/error state (pkt_cnt=0, err_cnt=0, err_flag=0); last_data still updates.
REQ-032 in_valid dropping while not granted SHALL be legal; no state change.

Reset
REQ-033 rst SHALL override clr and any transfer in the same cycle.
REQ-034 After rst: state IDLE, ptr=NCH-1 (channel 0 highest priority), HOLD counter 0.
REQ-035 After rst: pkt_cnt=0, err_cnt=0, err_flag=0, first_err=0, last_data=0, last_ch=0, acc_pulse=0.
REQ-036 in_ready SHALL be all-zero while rst is high; rst mid-HOLD aborts HOLD.

Verification
REQ-037 NCH=4, BL=0, NODE=5: all channels valid with dest 5 for 8 cycles -> grants 0,1,2,3,0,1,2,3, pkt_cnt=8, err_cnt=0.
REQ-038 BL=3: single channel 2 continuously valid -> in_ready[2] high 1 cycle in every 4, pkt_cnt=3 after 12 cycles.
REQ-039 NODE=5: packets dest 5, 7, 9 -> err_cnt=2, err_flag=1, first_err = dest-7 packet.
REQ-040 CNT_W=4: 20 valid packets -> pkt_cnt saturates at 15.
REQ-041 clr asserted on same edge as a misroute accept -> err_cnt=0, err_flag=0, last_data = that packet.
REQ-042 rst asserted in second HOLD cycle (BL=3) -> next cycle IDLE, all outputs 0, channel 0 granted first.
